// File: rtl/weight_sink.sv
// weight_sink: drains one kernel of MEM_SIZE coefficients from a FWFT-style
// FIFO into a single-port RAM, writing each word in the cycle it is popped.
module weight_sink #(
  parameter int MEM_SIZE   = 9,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = $clog2(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  output logic [AW-1:0]         weight_V_address0,
  output logic                  weight_V_ce0,
  output logic                  weight_V_we0,
  output logic [DATA_WIDTH-1:0] weight_V_d0,
  output logic                  busy,
  output logic                  loaded,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic          busy_q;
  logic          loaded_q;
  logic          done_q;

  // Pop strobe and RAM port are combinational so the write lands in the
  // same cycle the FIFO head is consumed; no skid register is needed.
  assign input_V_read      = (state_q == LOAD) && input_V_empty_n;
  assign weight_V_ce0      = input_V_read;
  assign weight_V_we0      = input_V_read;
  assign weight_V_d0       = input_V_dout;
  assign weight_V_address0 = addr_q;

  assign busy   = busy_q;
  assign loaded = loaded_q;
  assign done   = done_q;

  // Load sequencer: state, address counter and registered status flags.
  // NOTE: every register here uses <= so all flags see the pre-edge state.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= LOAD;
            addr_q   <= '0;
            busy_q   <= 1'b1;
            loaded_q <= 1'b0;
          end
        end
        LOAD: begin
          // An empty FIFO simply holds the counter; stalls are unbounded.
          if (input_V_empty_n) begin
            if (addr_q == LAST_ADDR) begin
              state_q  <= DONE;
              addr_q   <= '0;
              busy_q   <= 1'b0;
              loaded_q <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_sink.sv
// Directed bench for weight_sink: a queue models the FIFO, every cycle's
// outputs are traced on the falling edge and each scenario inspects the trace.
`timescale 1ns/1ps
module tb_weight_sink;

  localparam int MEM_SIZE   = 9;
  localparam int DATA_WIDTH = 16;
  localparam int AW         = $clog2(MEM_SIZE);

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic                  start;
  logic [DATA_WIDTH-1:0] input_V_dout;
  logic                  input_V_empty_n;
  logic                  input_V_read;
  logic [AW-1:0]         weight_V_address0;
  logic                  weight_V_ce0;
  logic                  weight_V_we0;
  logic [DATA_WIDTH-1:0] weight_V_d0;
  logic                  busy;
  logic                  loaded;
  logic                  done;

  weight_sink #(.MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DATA_WIDTH)) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .start            (start),
    .input_V_dout     (input_V_dout),
    .input_V_empty_n  (input_V_empty_n),
    .input_V_read     (input_V_read),
    .weight_V_address0(weight_V_address0),
    .weight_V_ce0     (weight_V_ce0),
    .weight_V_we0     (weight_V_we0),
    .weight_V_d0      (weight_V_d0),
    .busy             (busy),
    .loaded           (loaded),
    .done             (done)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic                  rd, ce, we, busy, loaded, done, empty_n;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] d;
  } smp_t;

  smp_t                  trace[$];
  logic [DATA_WIDTH-1:0] fifo[$];
  int tests = 0;
  int fails = 0;
  int cyc;
  bit toggle_mode;

  task automatic update_drive();
    input_V_empty_n = (fifo.size() > 0) && (!toggle_mode || (cyc % 2 == 1));
    if (fifo.size() > 0) input_V_dout = fifo[0];
    else                 input_V_dout = '0;
  endtask

  task automatic begin_test();
    trace.delete();
    cyc = 0;
    update_drive();
  endtask

  // One clock: sample on the falling edge, then consume the FIFO head
  // just after the rising edge if the DUT popped it.
  task automatic cycle();
    smp_t s;
    @(negedge ap_clk);
    s.rd = input_V_read;  s.ce = weight_V_ce0;  s.we = weight_V_we0;
    s.busy = busy;  s.loaded = loaded;  s.done = done;
    s.empty_n = input_V_empty_n;  s.addr = weight_V_address0;  s.d = weight_V_d0;
    trace.push_back(s);
    @(posedge ap_clk);
    #1;
    if (s.rd) void'(fifo.pop_front());
    cyc++;
    update_drive();
  endtask

  function automatic int n_writes();
    int n = 0;
    foreach (trace[i]) if (trace[i].we) n++;
    return n;
  endfunction

  function automatic int n_done();
    int n = 0;
    foreach (trace[i]) if (trace[i].done) n++;
    return n;
  endfunction

  function automatic int n_busy();
    int n = 0;
    foreach (trace[i]) if (trace[i].busy) n++;
    return n;
  endfunction

  // Index of the nth done pulse (0-based), or -1 if absent.
  function automatic int done_cycle(int nth);
    int n = 0;
    foreach (trace[i]) if (trace[i].done) begin
      if (n == nth) return i;
      n++;
    end
    return -1;
  endfunction

  function automatic int first_write();
    foreach (trace[i]) if (trace[i].we) return i;
    return -1;
  endfunction

  // Strobes that must mirror each other or the FIFO state.
  function automatic int n_strobe_errors();
    int n = 0;
    foreach (trace[i])
      if (trace[i].ce !== trace[i].rd || trace[i].we !== trace[i].rd ||
          (trace[i].rd && !trace[i].empty_n)) n++;
    return n;
  endfunction

  task automatic test_reset();
    ap_rst = 1'b1;
    start  = 1'b0;
    toggle_mode = 1'b0;
    fifo = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    begin_test();
    #2;
    tests++;
    if ({input_V_read, weight_V_ce0, weight_V_we0, busy, loaded, done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {input_V_read, weight_V_ce0, weight_V_we0, busy, loaded, done});
    end
    tests++;
    if (weight_V_address0 !== '0 || weight_V_d0 !== 16'hAAAA) begin
      fails++;
      $display("FAIL reset_ram_port: got addr %0d d %h expected addr 0 d aaaa",
               weight_V_address0, weight_V_d0);
    end
    start = 1'b1;
    repeat (3) cycle();
    tests++;
    if (fifo.size() != 3 || n_busy() != 0) begin
      fails++;
      $display("FAIL reset_hold: got fifo %0d busy %0d expected fifo 3 busy 0",
               fifo.size(), n_busy());
    end
    start  = 1'b0;
    ap_rst = 1'b0;
    fifo.delete();
    update_drive();
    repeat (2) cycle();
  endtask

  task automatic test_basic();
    int k = 0;
    for (int i = 0; i < MEM_SIZE; i++) fifo.push_back(DATA_WIDTH'(i + 1));
    begin_test();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (14) cycle();
    foreach (trace[i]) if (trace[i].we) begin
      tests++;
      if (trace[i].addr !== AW'(k) || trace[i].d !== DATA_WIDTH'(k + 1) || i != k + 1) begin
        fails++;
        $display("FAIL basic_write%0d: got cycle %0d addr %0d d %h expected cycle %0d addr %0d d %h",
                 k, i, trace[i].addr, trace[i].d, k + 1, k, k + 1);
      end
      k++;
    end
    tests++;
    if (k != 9) begin
      fails++;
      $display("FAIL basic_count: got %0d writes expected 9", k);
    end
    tests++;
    if (n_done() != 1 || done_cycle(0) != 10) begin
      fails++;
      $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 10", n_done(), done_cycle(0));
    end
    tests++;
    if (n_busy() != 9 || trace[10].loaded !== 1'b1 || loaded !== 1'b1) begin
      fails++;
      $display("FAIL basic_status: got busy %0d loaded %b/%b expected 9 1/1",
               n_busy(), trace[10].loaded, loaded);
    end
    tests++;
    if (n_strobe_errors() != 0) begin
      fails++;
      $display("FAIL basic_strobes: got %0d errors expected 0", n_strobe_errors());
    end
  endtask

  task automatic test_stall();
    int k = 0;
    toggle_mode = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) fifo.push_back(DATA_WIDTH'(16'h10 + i));
    begin_test();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (22) cycle();
    foreach (trace[i]) if (trace[i].we) begin
      tests++;
      if (trace[i].addr !== AW'(k) || trace[i].d !== DATA_WIDTH'(16'h10 + k) || i != 2 * k + 1) begin
        fails++;
        $display("FAIL stall_write%0d: got cycle %0d addr %0d d %h expected cycle %0d addr %0d d %h",
                 k, i, trace[i].addr, trace[i].d, 2 * k + 1, k, 16'h10 + k);
      end
      k++;
    end
    tests++;
    if (k != 9 || n_done() != 1 || done_cycle(0) != 18 || n_strobe_errors() != 0) begin
      fails++;
      $display("FAIL stall_summary: got writes %0d done %0d@%0d strobe_err %0d expected 9 1@18 0",
               k, n_done(), done_cycle(0), n_strobe_errors());
    end
    toggle_mode = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [DATA_WIDTH-1:0] ram [MEM_SIZE];
    for (int i = 0; i < MEM_SIZE; i++) fifo.push_back(DATA_WIDTH'(16'h20 + i));
    begin_test();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    ap_rst = 1'b1;
    #1;
    tests++;
    if ({input_V_read, weight_V_we0, busy, loaded} !== 4'b0 || weight_V_address0 !== '0) begin
      fails++;
      $display("FAIL midreset_abort: got rd/we/busy/loaded %b addr %0d expected 0000 addr 0",
               {input_V_read, weight_V_we0, busy, loaded}, weight_V_address0);
    end
    repeat (2) cycle();
    ap_rst = 1'b0;
    repeat (3) cycle();
    tests++;
    if (n_writes() != 4 || fifo.size() != 5 || loaded !== 1'b0) begin
      fails++;
      $display("FAIL midreset_quiet: got writes %0d fifo %0d loaded %b expected 4 5 0",
               n_writes(), fifo.size(), loaded);
    end
    fifo.delete();
    for (int i = 0; i < MEM_SIZE; i++) begin
      fifo.push_back(DATA_WIDTH'(16'h100 + i));
      ram[i] = 'x;
    end
    begin_test();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (13) cycle();
    foreach (trace[i]) if (trace[i].we) ram[trace[i].addr] = trace[i].d;
    tests++;
    if (trace[first_write()].addr !== '0) begin
      fails++;
      $display("FAIL midreset_restart: got first addr %0d expected 0", trace[first_write()].addr);
    end
    for (int i = 0; i < MEM_SIZE; i++) begin
      tests++;
      if (ram[i] !== DATA_WIDTH'(16'h100 + i)) begin
        fails++;
        $display("FAIL midreset_ram%0d: got %h expected %h", i, ram[i], 16'h100 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    for (int i = 0; i < 2 * MEM_SIZE; i++) fifo.push_back(DATA_WIDTH'(16'h30 + i));
    begin_test();
    start = 1'b1;
    repeat (22) cycle();
    start = 1'b0;
    repeat (4) cycle();
    foreach (trace[i]) if (trace[i].we) begin
      tests++;
      if (trace[i].addr !== AW'(k % MEM_SIZE) || trace[i].d !== DATA_WIDTH'(16'h30 + k)) begin
        fails++;
        $display("FAIL b2b_write%0d: got addr %0d d %h expected addr %0d d %h",
                 k, trace[i].addr, trace[i].d, k % MEM_SIZE, 16'h30 + k);
      end
      k++;
    end
    tests++;
    if (k != 18 || n_done() != 2 || done_cycle(0) != 10 || done_cycle(1) != 21) begin
      fails++;
      $display("FAIL b2b_done: got writes %0d done %0d at %0d,%0d expected 18 2 at 10,21",
               k, n_done(), done_cycle(0), done_cycle(1));
    end
    tests++;
    if (trace[11].loaded !== 1'b1 || trace[12].loaded !== 1'b0 ||
        trace[20].loaded !== 1'b0 || trace[21].loaded !== 1'b1) begin
      fails++;
      $display("FAIL b2b_loaded: got %b%b%b%b at 11,12,20,21 expected 1001",
               trace[11].loaded, trace[12].loaded, trace[20].loaded, trace[21].loaded);
    end
  endtask

  task automatic test_start_during_load();
    for (int i = 0; i < MEM_SIZE + 1; i++) fifo.push_back(DATA_WIDTH'(16'h50 + i));
    begin_test();
    for (int i = 0; i < 16; i++) begin
      start = (i == 0) || (i == 5);
      cycle();
    end
    start = 1'b0;
    tests++;
    if (n_writes() != 9 || n_done() != 1 || fifo.size() != 1) begin
      fails++;
      $display("FAIL restart_ignored: got writes %0d done %0d fifo %0d expected 9 1 1",
               n_writes(), n_done(), fifo.size());
    end
    tests++;
    if (fifo.size() == 0 || fifo[0] !== 16'h59) begin
      fails++;
      $display("FAIL restart_leftover: got fifo size %0d expected head 0059", fifo.size());
    end
    fifo.delete();
    update_drive();
  endtask

  task automatic test_no_start();
    int n_loaded = 0;
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    for (int i = 0; i < 20; i++) fifo.push_back(DATA_WIDTH'(16'h70 + i));
    begin_test();
    repeat (20) cycle();
    foreach (trace[i]) if (trace[i].loaded || trace[i].rd) n_loaded++;
    tests++;
    if (n_writes() != 0 || n_done() != 0 || n_loaded != 0 || fifo.size() != 20) begin
      fails++;
      $display("FAIL no_start: got writes %0d done %0d loaded/rd %0d fifo %0d expected 0 0 0 20",
               n_writes(), n_done(), n_loaded, fifo.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid_load();
    test_back_to_back();
    test_start_during_load();
    test_no_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
